reservation_station: RTL

RESERVATION_STATION -- requirements
Module: reservation_station

---
 rtl/reservation_station_pkg.sv | 31 +++
 rtl/reservation_station_find_first.sv | 27 ++
 rtl/reservation_station.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/reservation_station_pkg.sv
// Shared definitions for the reservation station: operation codes, data and
// tag widths, station depth, and a small index-width helper.
package reservation_station_pkg;

    localparam int INST_TYPE_WIDTH = 6;
    localparam int DATA_W          = 32;
    localparam int ROB_TAG_W       = 4;
    localparam int RS_SIZE         = 8;

    // Decoded operation codes carried through the station untouched.
    typedef enum logic [INST_TYPE_WIDTH-1:0] {
        OP_NOP  = 6'd0,
        OP_ADD  = 6'd1,
        OP_SUB  = 6'd2,
        OP_ADDI = 6'd3,
        OP_AND  = 6'd4,
        OP_OR   = 6'd5,
        OP_XOR  = 6'd6,
        OP_SLL  = 6'd7,
        OP_SRL  = 6'd8,
        OP_LUI  = 6'd9,
        OP_BEQ  = 6'd10,
        OP_BNE  = 6'd11
    } op_e;

    // Width of an index into n entries; never zero so a 1-entry station still works.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reservation_station_find_first.sv
// Lowest-index priority encoder with a found flag. Used both to pick the free
// slot for dispatch and the oldest-by-position ready entry for issue.
module rs_find_first
    import reservation_station_pkg::*;
#(
    parameter int N = 8,
    parameter int W = idx_width(N)
) (
    input  logic [N-1:0] req,
    output logic         found,
    output logic [W-1:0] idx
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        // NOTE: every output gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = W'(i);
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Reservation station: holds dispatched operations until both operands are
// available (snooping the CDB for pending ones), then issues the lowest-index
// ready entry into registered ex_* outputs, one per cycle.
module reservation_station
    import reservation_station_pkg::INST_TYPE_WIDTH;
    import reservation_station_pkg::DATA_W;
    import reservation_station_pkg::idx_width;
#(
    parameter int RS_SIZE   = reservation_station_pkg::RS_SIZE,
    parameter int ROB_TAG_W = reservation_station_pkg::ROB_TAG_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic                       clear,
    input  logic                       in_valid,
    input  logic [INST_TYPE_WIDTH-1:0] in_ordertype,
    input  logic [DATA_W-1:0]          in_vj,
    input  logic [DATA_W-1:0]          in_vk,
    input  logic                       in_qj_busy,
    input  logic                       in_qk_busy,
    input  logic [ROB_TAG_W-1:0]       in_qj,
    input  logic [ROB_TAG_W-1:0]       in_qk,
    input  logic [DATA_W-1:0]          in_A,
    input  logic [DATA_W-1:0]          in_pc,
    input  logic [ROB_TAG_W-1:0]       in_rob_tag,
    output logic                       full,
    input  logic                       cdb_valid,
    input  logic [ROB_TAG_W-1:0]       cdb_tag,
    input  logic [DATA_W-1:0]          cdb_value,
    output logic                       ex_valid,
    output logic [INST_TYPE_WIDTH-1:0] ex_ordertype,
    output logic [DATA_W-1:0]          ex_vj,
    output logic [DATA_W-1:0]          ex_vk,
    output logic [DATA_W-1:0]          ex_A,
    output logic [DATA_W-1:0]          ex_pc,
    output logic [ROB_TAG_W-1:0]       ex_rob_tag
);

    localparam int IDX_W = idx_width(RS_SIZE);

    // Control state (reset) and payload (not reset) kept in separate arrays.
    logic [RS_SIZE-1:0]         busy;
    logic [RS_SIZE-1:0]         qj_busy;
    logic [RS_SIZE-1:0]         qk_busy;
    logic [INST_TYPE_WIDTH-1:0] e_type [RS_SIZE];
    logic [DATA_W-1:0]          e_vj   [RS_SIZE];
    logic [DATA_W-1:0]          e_vk   [RS_SIZE];
    logic [DATA_W-1:0]          e_a    [RS_SIZE];
    logic [DATA_W-1:0]          e_pc   [RS_SIZE];
    logic [ROB_TAG_W-1:0]       e_qj   [RS_SIZE];
    logic [ROB_TAG_W-1:0]       e_qk   [RS_SIZE];
    logic [ROB_TAG_W-1:0]       e_tag  [RS_SIZE];

    logic [RS_SIZE-1:0] ready_vec;
    logic               free_found;
    logic               ready_found;
    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   ready_idx;
    logic               do_dispatch;
    logic               j_hit;
    logic               k_hit;

    // Ready is judged on registered state only, so a wakeup never issues in the same cycle.
    assign ready_vec = busy & ~qj_busy & ~qk_busy;

    rs_find_first #(.N(RS_SIZE), .W(IDX_W)) u_free_sel (
        .req   (~busy),
        .found (free_found),
        .idx   (free_idx)
    );

    rs_find_first #(.N(RS_SIZE), .W(IDX_W)) u_ready_sel (
        .req   (ready_vec),
        .found (ready_found),
        .idx   (ready_idx)
    );

    assign full        = ~free_found;
    assign do_dispatch = rdy & ~clear & in_valid & free_found;
    // An operand produced by this cycle's broadcast is captured at dispatch.
    assign j_hit       = in_qj_busy & cdb_valid & (cdb_tag == in_qj);
    assign k_hit       = in_qk_busy & cdb_valid & (cdb_tag == in_qk);

    // Entry control bits and the issue register: reset, freeze, flush, then wake/issue/dispatch.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            busy         <= '0;
            qj_busy      <= '0;
            qk_busy      <= '0;
            ex_valid     <= 1'b0;
            ex_ordertype <= '0;
            ex_vj        <= '0;
            ex_vk        <= '0;
            ex_A         <= '0;
            ex_pc        <= '0;
            ex_rob_tag   <= '0;
        end else if (rdy) begin
            if (clear) begin
                busy     <= '0;
                ex_valid <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy[i] && cdb_valid && qj_busy[i] && e_qj[i] == cdb_tag) qj_busy[i] <= 1'b0;
                    if (busy[i] && cdb_valid && qk_busy[i] && e_qk[i] == cdb_tag) qk_busy[i] <= 1'b0;
                end
                if (ready_found) begin
                    ex_valid        <= 1'b1;
                    ex_ordertype    <= e_type[ready_idx];
                    ex_vj           <= e_vj[ready_idx];
                    ex_vk           <= e_vk[ready_idx];
                    ex_A            <= e_a[ready_idx];
                    ex_pc           <= e_pc[ready_idx];
                    ex_rob_tag      <= e_tag[ready_idx];
                    busy[ready_idx] <= 1'b0;
                end else begin
                    ex_valid <= 1'b0;
                end
                // The free slot is never the issuing slot, so these writes cannot collide.
                if (do_dispatch) begin
                    busy[free_idx]    <= 1'b1;
                    qj_busy[free_idx] <= in_qj_busy & ~j_hit;
                    qk_busy[free_idx] <= in_qk_busy & ~k_hit;
                end
            end
        end
    end

    // Entry payload: operand capture from the CDB and dispatch writes.
    always_ff @(posedge clk) begin
        // NOTE: payload arrays are not reset; they are only read while the matching busy bit is set.
        if (rst && do_dispatch) begin
            e_type[free_idx] <= in_ordertype;
            e_vj[free_idx]   <= j_hit ? cdb_value : in_vj;
            e_vk[free_idx]   <= k_hit ? cdb_value : in_vk;
            e_a[free_idx]    <= in_A;
            e_pc[free_idx]   <= in_pc;
            e_qj[free_idx]   <= in_qj;
            e_qk[free_idx]   <= in_qk;
            e_tag[free_idx]  <= in_rob_tag;
        end
        if (rst && rdy && !clear) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy[i] && cdb_valid && qj_busy[i] && e_qj[i] == cdb_tag) e_vj[i] <= cdb_value;
                if (busy[i] && cdb_valid && qk_busy[i] && e_qk[i] == cdb_tag) e_vk[i] <= cdb_value;
            end
        end
    end

endmodule
